// File: rtl/pma_region_scanner_if.sv
// Request/response bus between a PMA requester and pma_region_scanner; the requester
// holds the master modport, the scanner the slave modport.
interface pma_region_scanner_if #(
  parameter int unsigned PLEN = 56
);
  logic            flush_i;
  logic            req_valid_i;
  logic            req_ready_o;
  logic [PLEN-1:0] req_paddr_i;
  logic            rsp_valid_o;
  logic            rsp_ready_i;
  logic [PLEN-1:0] rsp_paddr_o;
  logic            rsp_cacheable_o;
  logic            rsp_nonidempotent_o;
  logic            rsp_executable_o;

  modport master (
    output flush_i, req_valid_i, req_paddr_i, rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_paddr_o,
           rsp_cacheable_o, rsp_nonidempotent_o, rsp_executable_o
  );

  modport slave (
    input  flush_i, req_valid_i, req_paddr_i, rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_paddr_o,
           rsp_cacheable_o, rsp_nonidempotent_o, rsp_executable_o
  );
endinterface

// File: rtl/pma_region_scanner.sv
// Iterative PMA classifier: one rule index per cycle across cached/non-idempotent/execute tables.
// Response after NrScan+1 cycles; one request in flight, response held until rsp_ready_i, flush aborts.
module pma_region_scanner #(
  parameter int unsigned PLEN                 = 56,
  parameter int unsigned MaxRules             = 8,
  parameter int unsigned NrCachedRegionRules  = 0,
  parameter logic [MaxRules-1:0][63:0] CachedRegionAddrBase  = '0,
  parameter logic [MaxRules-1:0][63:0] CachedRegionLength    = '0,
  parameter int unsigned NrNonIdempotentRules = 0,
  parameter logic [MaxRules-1:0][63:0] NonIdempotentAddrBase = '0,
  parameter logic [MaxRules-1:0][63:0] NonIdempotentLength   = '0,
  parameter int unsigned NrExecuteRegionRules = 0,
  parameter logic [MaxRules-1:0][63:0] ExecuteRegionAddrBase = '0,
  parameter logic [MaxRules-1:0][63:0] ExecuteRegionLength   = '0
) (
  input logic                  clk_i,
  input logic                  rst_ni,
  pma_region_scanner_if.slave  bus
);
  localparam int unsigned NrCn   = (NrCachedRegionRules > NrNonIdempotentRules) ?
                                   NrCachedRegionRules : NrNonIdempotentRules;
  localparam int unsigned NrScan = (NrCn > NrExecuteRegionRules) ? NrCn : NrExecuteRegionRules;
  localparam int unsigned IdxW   = (MaxRules > 1) ? $clog2(MaxRules) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'((NrScan == 0) ? 0 : NrScan - 1);

  typedef enum logic [1:0] {IDLE, SCAN, RESP} state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [PLEN-1:0] addr_q, addr_d;
  logic            cach_q, cach_d, nidem_q, nidem_d, exec_q, exec_d;
  logic            req_ready;
  logic [63:0]     addr64;
  logic [63:0]     c_base, c_len, n_base, n_len, x_base, x_len;
  logic            c_hit, n_hit, x_hit;

  // Upper bound is exclusive and computed in 65 bits so base+length never wraps.
  function automatic logic in_region(logic [63:0] a, logic [63:0] base, logic [63:0] len);
    return (base <= a) && ({1'b0, a} < ({1'b0, base} + {1'b0, len}));
  endfunction

  assign addr64    = 64'(addr_q);
  assign req_ready = (state_q == IDLE) && !bus.flush_i;

  always_comb begin
    c_base = '0; c_len = '0; n_base = '0; n_len = '0; x_base = '0; x_len = '0;
    for (int k = 0; k < MaxRules; k++) begin
      if (idx_q == IdxW'(k)) begin
        c_base = CachedRegionAddrBase[k];  c_len = CachedRegionLength[k];
        n_base = NonIdempotentAddrBase[k]; n_len = NonIdempotentLength[k];
        x_base = ExecuteRegionAddrBase[k]; x_len = ExecuteRegionLength[k];
      end
    end
    // Entries past a table's count may hold anything and must never contribute.
    c_hit = (32'(idx_q) < NrCachedRegionRules)  && in_region(addr64, c_base, c_len);
    n_hit = (32'(idx_q) < NrNonIdempotentRules) && in_region(addr64, n_base, n_len);
    x_hit = (32'(idx_q) < NrExecuteRegionRules) && in_region(addr64, x_base, x_len);
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    cach_d  = cach_q;
    nidem_d = nidem_q;
    exec_d  = exec_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid_i && req_ready) begin
          addr_d  = bus.req_paddr_i;
          cach_d  = 1'b0;
          nidem_d = 1'b0;
          exec_d  = 1'b0;
          idx_d   = '0;
          state_d = (NrScan == 0) ? RESP : SCAN;
        end
      end
      SCAN: begin
        cach_d  = cach_q  | c_hit;
        nidem_d = nidem_q | n_hit;
        exec_d  = exec_q  | x_hit;
        if (idx_q == LastIdx) state_d = RESP;
        else                  idx_d   = idx_q + IdxW'(1);
      end
      RESP: begin
        if (bus.rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (bus.flush_i) begin
      state_d = IDLE;
      idx_d   = '0;
      cach_d  = 1'b0;
      nidem_d = 1'b0;
      exec_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      idx_q   <= '0;
      addr_q  <= '0;
      cach_q  <= 1'b0;
      nidem_q <= 1'b0;
      exec_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      cach_q  <= cach_d;
      nidem_q <= nidem_d;
      exec_q  <= exec_d;
    end
  end

  assign bus.req_ready_o         = req_ready;
  assign bus.rsp_valid_o         = (state_q == RESP);
  assign bus.rsp_paddr_o         = addr_q;
  assign bus.rsp_cacheable_o     = cach_q;
  assign bus.rsp_nonidempotent_o = nidem_q;
  assign bus.rsp_executable_o    = exec_q;
endmodule
